// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, instruction
// classes, RV64 opcode/funct fields and the ALU control codes.
package ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_ST,
    CLS_BR
  } instr_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: maps opcode/funct3/funct7 to an ALU
// control code and an instruction class, flagging anything unsupported.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output logic [3:0]   alucc,
  output instr_class_t iclass,
  output logic         illegal
);

  always_comb begin
    alucc   = ALU_ADD;
    iclass  = CLS_R;
    illegal = 1'b1;
    case (opcode)
      OP_R: begin
        iclass = CLS_R;
        if (funct3 == F3_ADD && funct7 == F7_BASE) begin
          alucc = ALU_ADD; illegal = 1'b0;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          alucc = ALU_SUB; illegal = 1'b0;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          alucc = ALU_AND; illegal = 1'b0;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          alucc = ALU_OR; illegal = 1'b0;
        end
      end
      OP_I: begin
        iclass = CLS_I;
        case (funct3)
          F3_ADD:  begin alucc = ALU_ADD; illegal = 1'b0; end
          F3_AND:  begin alucc = ALU_AND; illegal = 1'b0; end
          F3_OR:   begin alucc = ALU_OR;  illegal = 1'b0; end
          default: illegal = 1'b1;
        endcase
      end
      OP_LD: begin
        iclass  = CLS_LD;
        illegal = (funct3 != F3_DW);
      end
      OP_ST: begin
        iclass  = CLS_ST;
        illegal = (funct3 != F3_DW);
      end
      OP_BR: begin
        iclass  = CLS_BR;
        alucc   = ALU_SUB;
        illegal = (funct3 != F3_BEQ);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: latches one instruction per handshake and walks it
// through decode/execute/memory/writeback, driving ALU and strobe controls.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH   = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [INSTR_WIDTH-1:0]   Instr,
  output logic                     instr_ready,
  input  logic                     Zero,
  input  logic                     mem_ready,
  output logic [OPCODE_LENGTH-1:0] ALUCC,
  output logic                     SrcBSel,
  output logic                     RegWrite,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     MemtoReg,
  output logic                     PCSrc,
  output logic                     done,
  output logic                     illegal
);

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;

  logic [3:0]   dec_alucc;
  instr_class_t dec_class;
  logic         dec_illegal;
  logic [3:0]   alucc;

  // Register/immediate fields are consumed by the datapath, not by control.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

  alu_op_decode u_dec (
    .opcode  (ir_q[6:0]),
    .funct3  (ir_q[14:12]),
    .funct7  (ir_q[31:25]),
    .alucc   (dec_alucc),
    .iclass  (dec_class),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_IDLE;
        end else begin
          case (dec_class)
            CLS_R:   state_d = S_EXEC_R;
            CLS_I:   state_d = S_EXEC_I;
            CLS_LD:  state_d = S_MEM_ADDR;
            CLS_ST:  state_d = S_MEM_ADDR;
            CLS_BR:  state_d = S_BRANCH;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_IDLE;
      S_MEM_ADDR:  state_d = (dec_class == CLS_LD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_IDLE;
      S_MEM_WRITE: if (mem_ready) state_d = S_IDLE;
      S_BRANCH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    alucc       = ALU_AND;
    SrcBSel     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE:   instr_ready = 1'b1;
      S_DECODE: begin
        alucc   = ALU_ADD;
        illegal = dec_illegal;
      end
      S_EXEC_R: alucc = dec_alucc;
      S_EXEC_I: begin
        alucc   = dec_alucc;
        SrcBSel = 1'b1;
      end
      S_ALU_WB: begin
        alucc    = dec_alucc;
        SrcBSel  = (dec_class == CLS_I);
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      S_MEM_ADDR: begin
        alucc   = ALU_ADD;
        SrcBSel = 1'b1;
      end
      S_MEM_READ: begin
        alucc   = ALU_ADD;
        SrcBSel = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      S_MEM_WRITE: begin
        alucc    = ALU_ADD;
        SrcBSel  = 1'b1;
        MemWrite = 1'b1;
        done     = mem_ready;
      end
      S_BRANCH: begin
        alucc = ALU_SUB;
        done  = 1'b1;
        PCSrc = Zero;
      end
      default: ;
    endcase
  end

  assign ALUCC = OPCODE_LENGTH'(alucc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected
// retire vectors; a monitor compares them whenever done or illegal pulses.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] Instr;
  logic        instr_ready;
  logic        Zero;
  logic        mem_ready;
  logic [3:0]  ALUCC;
  logic        SrcBSel, RegWrite, MemRead, MemWrite, MemtoReg, PCSrc, done, illegal;

  multicycle_ctrl #(.INSTR_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .instr_ready (instr_ready),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .ALUCC       (ALUCC),
    .SrcBSel     (SrcBSel),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .PCSrc       (PCSrc),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] outs;
    int unsigned delta;
    int unsigned memrd;
    int unsigned exp_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned mem_wait = 0;
  int unsigned mem_cnt = 0;
  int unsigned memrd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {instr_ready, illegal, done, ALUCC, SrcBSel, RegWrite, MemtoReg, MemWrite, MemRead, PCSrc}
  function automatic logic [12:0] outs();
    return {instr_ready, illegal, done, ALUCC, SrcBSel, RegWrite, MemtoReg,
            MemWrite, MemRead, PCSrc};
  endfunction

  function automatic exp_t mk(input logic ill, input logic [3:0] cc, input logic srcb,
                              input logic rw, input logic m2r, input logic mw,
                              input logic pcs, input int unsigned delta,
                              input int unsigned memrd);
    exp_t e;
    e.outs    = {1'b0, ill, ~ill, cc, srcb, rw, m2r, mw, 1'b0, pcs};
    e.delta   = delta;
    e.memrd   = memrd;
    e.exp_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: after mem_wait stalled cycles of a request, mem_ready rises.
  // Outside a request it is held high, which the controller must ignore.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (MemRead || MemWrite) begin
        mem_ready = (mem_cnt == mem_wait);
        mem_cnt++;
      end else begin
        mem_ready = 1'b1;
        mem_cnt   = 0;
      end
    end
  end

  // Monitor: pops one expectation per retire/illegal pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) memrd_cnt = 0;
      else if (MemRead) memrd_cnt++;
      if (RegWrite && !done) chk("regwrite_without_done", {31'd0, RegWrite}, 32'd0);
      if (done || illegal) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", {19'd0, outs()}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("retire_outs", {19'd0, outs()}, {19'd0, e.outs});
          chk("retire_cycle", cyc, e.exp_cyc);
          chk("memread_cycles", memrd_cnt, e.memrd);
        end
        memrd_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!instr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Presents ins at a negedge, accepts on the next edge N, then checks that
  // instr_ready returns in cycle N+ready_off.
  task automatic issue(input logic [31:0] ins, input exp_t e, input int unsigned ready_off,
                       input int unsigned wait_k);
    int unsigned n;
    mem_wait = wait_k;
    wait_ready();
    instr_valid = 1'b1;
    Instr       = ins;
    @(posedge clk);
    #1;
    n         = cyc;
    Instr     = 32'hFFFF_FFFF;
    e.exp_cyc = n + e.delta - 1;
    sb.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_ready();
    chk("ready_return_cycle", cyc, n + ready_off - 1);
  endtask

  initial begin
    int t;
    reset       = 1'b1;
    instr_valid = 1'b1;
    Instr       = 32'h0000_12B7;
    Zero        = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {19'd0, outs()}, 32'h1000);
    reset       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("reset_wins_accept", {19'd0, outs()}, 32'h1000);

    issue(32'h4020_81B3, mk(0, 4'b0110, 0, 1, 0, 0, 0, 3, 0), 4, 0);  // sub
    issue(32'h0020_81B3, mk(0, 4'b0010, 0, 1, 0, 0, 0, 3, 0), 4, 0);  // add
    issue(32'h0020_F1B3, mk(0, 4'b0000, 0, 1, 0, 0, 0, 3, 0), 4, 0);  // and
    issue(32'h0020_E1B3, mk(0, 4'b0001, 0, 1, 0, 0, 0, 3, 0), 4, 0);  // or
    issue(32'h0050_0093, mk(0, 4'b0010, 1, 1, 0, 0, 0, 3, 0), 4, 0);  // addi
    issue(32'h0070_F093, mk(0, 4'b0000, 1, 1, 0, 0, 0, 3, 0), 4, 0);  // andi
    issue(32'h0080_B283, mk(0, 4'b0000, 0, 1, 1, 0, 0, 4, 1), 5, 0);  // ld, no wait
    issue(32'h0080_B283, mk(0, 4'b0000, 0, 1, 1, 0, 0, 7, 4), 8, 3);  // ld, 3 waits
    issue(32'h0050_B423, mk(0, 4'b0010, 1, 0, 0, 1, 0, 3, 0), 4, 0);  // sd, no wait
    issue(32'h0050_B423, mk(0, 4'b0010, 1, 0, 0, 1, 0, 5, 0), 6, 2);  // sd, 2 waits
    Zero = 1'b1;
    issue(32'h0020_8463, mk(0, 4'b0110, 0, 0, 0, 0, 1, 2, 0), 3, 0);  // beq taken
    Zero = 1'b0;
    issue(32'h0020_8463, mk(0, 4'b0110, 0, 0, 0, 0, 0, 2, 0), 3, 0);  // beq not taken
    issue(32'h0000_12B7, mk(1, 4'b0010, 0, 0, 0, 0, 0, 1, 0), 2, 0);  // lui
    issue(32'h0220_81B3, mk(1, 4'b0010, 0, 0, 0, 0, 0, 1, 0), 2, 0);  // mul
    issue(32'h0060_C093, mk(1, 4'b0010, 0, 0, 0, 0, 0, 1, 0), 2, 0);  // xori
    issue(32'h0080_A283, mk(1, 4'b0010, 0, 0, 0, 0, 0, 1, 0), 2, 0);  // lw

    // sd stalled indefinitely, then reset during the MEM_WRITE wait.
    mem_wait = 1000;
    wait_ready();
    instr_valid = 1'b1;
    Instr       = 32'h0050_B423;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    t = 0;
    while (!MemWrite && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_memwrite", {31'd0, MemWrite}, 32'd1);
    chk("stall_no_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_reset_outs", {19'd0, outs()}, 32'h1000);
    reset    = 1'b0;
    mem_wait = 0;
    @(negedge clk);
    chk("abort_idle_outs", {19'd0, outs()}, 32'h1000);

    issue(32'h0060_E093, mk(0, 4'b0001, 1, 1, 0, 0, 0, 3, 0), 4, 0);  // ori

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that drives the 64-bit ALU's `ALUCC` and operand-select inputs, plus register-file and data-memory strobes. It sits upstream of the ALU and is the producer of its control code. It accepts one 32-bit RV64 instruction per handshake and sequences it through decode, execute, memory and writeback over several cycles. It supports the ALU's four operations: AND, OR, ADD, SUB.

## Interface

Parameters:
- `INSTR_WIDTH`, 32, instruction word width.
- `OPCODE_LENGTH`, 4, width of `ALUCC`; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  an instruction is presented on `Instr`.
- `Instr`  in  `INSTR_WIDTH`  instruction word; sampled only on accept.
- `instr_ready`  out  1  high only in IDLE.
- `Zero`  in  1  ALU result equals 0; sampled in BRANCH.
- `mem_ready`  in  1  data memory has completed the current read or write.
- `ALUCC`  out  `OPCODE_LENGTH`  ALU control code.
- `SrcBSel`  out  1  0 selects register rs2, 1 selects immediate.
- `RegWrite`  out  1  register-file write strobe.
- `MemRead`  out  1  data-memory read request.
- `MemWrite`  out  1  data-memory write request.
- `MemtoReg`  out  1  writeback data taken from memory.
- `PCSrc`  out  1  branch taken; one-cycle pulse.
- `done`  out  1  instruction retired; one-cycle pulse.
- `illegal`  out  1  unsupported instruction; one-cycle pulse.

## Operation

- ALUCC codes: AND=0000, OR=0001, ADD=0010, SUB=0110.
- Accept: when `instr_valid && instr_ready`, `Instr` is latched into the internal IR and the FSM moves IDLE→DECODE. The IR is not reloaded until the next accept.
- Decode from the IR (opcode[6:0], funct3[14:12], funct7[31:25]):
  - R-type 0110011:
    - funct3 000, funct7 0000000 → ADD.
    - funct3 000, funct7 0100000 → SUB.
    - funct3 111, funct7 0000000 → AND.
    - funct3 110, funct7 0000000 → OR.
  - I-type 0010011: funct3 000/111/110 → ADD/AND/OR.
  - Load 0000011 with funct3 011 (ld) → ADD.
  - Store 0100011 with funct3 011 (sd) → ADD.
  - Branch 1100011 with funct3 000 (beq) → SUB.
  - Anything else is illegal.
- States and transitions:
  - IDLE: accept → DECODE.
  - DECODE:
    - R → EXEC_R.
    - I → EXEC_I.
    - ld/sd → MEM_ADDR.
    - beq → BRANCH.
    - illegal → IDLE with `illegal`=1 in DECODE.
  - EXEC_R → ALU_WB.
  - EXEC_I → ALU_WB.
  - ALU_WB → IDLE.
  - MEM_ADDR: ld → MEM_READ; sd → MEM_WRITE.
  - MEM_READ: stays until `mem_ready`, then → MEM_WB.
  - MEM_WB → IDLE.
  - MEM_WRITE: stays until `mem_ready`, then → IDLE.
  - BRANCH → IDLE.
- Moore outputs per state (every unlisted output is 0):
  - DECODE: `ALUCC`=ADD.
  - EXEC_R: `ALUCC`=decoded code, `SrcBSel`=0.
  - EXEC_I: `ALUCC`=decoded code, `SrcBSel`=1.
  - ALU_WB: `ALUCC` and `SrcBSel` hold their EXEC values; `RegWrite`=1, `done`=1.
  - MEM_ADDR: `ALUCC`=ADD, `SrcBSel`=1.
  - MEM_READ: `MemRead`=1, address inputs held as in MEM_ADDR.
  - MEM_WB: `MemtoReg`=1, `RegWrite`=1, `done`=1.
  - MEM_WRITE: `MemWrite`=1, ADD/imm held; `done`=1 in the cycle `mem_ready` is seen.
  - BRANCH: `ALUCC`=SUB, `SrcBSel`=0, `done`=1, `PCSrc`=`Zero`.
- `ALUCC` in IDLE is 0000.

## Timing

- Reset:
  - State goes to IDLE at the next edge.
  - Every output except `instr_ready` is 0 in the cycle after reset is sampled; `instr_ready`=1.
  - Reset mid-instruction abandons the instruction with no `done`, `RegWrite` or `MemWrite`.
  - Reset wins over a simultaneous accept.
- Latency, with accept at edge N:
  - R/I: EXEC at cycle N+2, `RegWrite`/`done` at N+3, `instr_ready` at N+4.
  - ld with zero wait: `MemRead` at N+3, `RegWrite` at N+4.
  - ld with k cycles of `mem_ready` low: `RegWrite` at N+4+k.
  - sd with zero wait: `MemWrite`/`done` at N+3.
  - beq: `PCSrc`/`done` at N+2.
  - illegal: `illegal` at N+1, `instr_ready` at N+2.
- `instr_valid` while busy is ignored. No back-to-back accept: minimum spacing is 2 cycles (illegal) and 3 cycles (beq).
- `mem_ready` outside MEM_READ and MEM_WRITE is ignored.

## Structure

- Package `ctrl_pkg`:
  - `state_t` enum.
  - ALUCC localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`.
  - Opcode localparams `OP_R`, `OP_I`, `OP_LD`, `OP_ST`, `OP_BR`.
- Sub-module `alu_op_decode`: combinational; inputs opcode, funct3 and funct7; outputs `ALUCC`, instruction class and illegal flag.
- Top module: IR register, state register, next-state logic and Moore output decode.

## Test plan

- Reset held for 2 cycles → `instr_ready`=1, `ALUCC`=0000, all strobes 0.
- Accept `sub x3,x1,x2` (0x402081B3) at N → `ALUCC`=0110, `SrcBSel`=0 at N+2; `RegWrite`=1, `done`=1 at N+3.
- Accept `ld x5,8(x1)` (0x0080B283) with `mem_ready` low for 3 cycles → `MemRead` high for 4 cycles; `MemtoReg`=`RegWrite`=1 at N+7.
- Accept `beq x1,x2,..` (0x00208463): with `Zero`=1 → `PCSrc`=1 at N+2; with `Zero`=0 → `PCSrc`=0, `done`=1.
- Accept opcode 0110111 (lui) → `illegal`=1 at N+1; no `RegWrite`; `instr_ready`=1 at N+2.
- Assert reset during MEM_WRITE wait → no `MemWrite` or `done` after reset; IDLE next cycle; a new `ori` (funct3 110) completes with `ALUCC`=0001, `SrcBSel`=1.
